// File: rtl/link_rx_responder.sv
// Receive end of the 4-phase req/ack byte link; bytes land in a show-ahead FIFO, ack follows acceptance by one cycle.
// ack is withheld while the FIFO is full and asserts the cycle after a pop frees a slot.
module link_rx_responder #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int ACK_HOLD = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [DATA_W-1:0] xor_sum,
  output logic              busy
);

  localparam int AW       = $clog2(DEPTH);
  localparam int HOLD_EFF = (ACK_HOLD < 1) ? 1 : ACK_HOLD;
  localparam int HW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_LOW} state_t;

  state_t            state, state_nxt;
  logic              ack_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic              push, pop;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ack_nxt   = ack;
    hold_nxt  = hold_cnt;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (req && !full) begin
          push      = 1'b1;
          ack_nxt   = 1'b1;
          hold_nxt  = HW'(HOLD_EFF - 1);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // req is not looked at until the minimum hold time has elapsed
        if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - HW'(1);
        end else if (!req) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        ack_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ack      <= 1'b0;
      hold_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byte_cnt <= '0;
      xor_sum  <= '0;
    end else begin
      state    <= state_nxt;
      ack      <= ack_nxt;
      hold_cnt <= hold_nxt;
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        byte_cnt <= byte_cnt + CNT_W'(1);
        xor_sum  <= xor_sum ^ data;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

endmodule

// File: tb/tb_link_rx_responder.sv
// Randomized bench for link_rx_responder against a queue-based model of the link and FIFO.
module tb_link_rx_responder;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int ACK_HOLD = 2;
  localparam int CNT_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic [DATA_W-1:0] data;
  logic              ack;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] xor_sum;
  logic              busy;

  link_rx_responder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_HOLD(ACK_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .byte_cnt(byte_cnt), .xor_sum(xor_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mq[$];
  int                m_cnt;
  logic [DATA_W-1:0] m_xor;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [DATA_W-1:0] d);
    mq.push_back(d);
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_xor = m_xor ^ d;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(m_cnt));
    check({tag, "_xor_sum"}, 32'(xor_sum), 32'(m_xor));
    check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; rd_en = 1'b0; data = '0;
    repeat (3) tick();
    rst = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_xor = '0;
  endtask

  // Full handshake; master keeps req high for 'extra' cycles after it sees ack.
  task automatic send_byte(input logic [DATA_W-1:0] d, input int extra);
    int hi;
    int waited;
    int exp_hi;
    req = 1'b1; data = d;
    waited = 0;
    while (!ack && waited < 200) begin
      tick();
      waited++;
    end
    if (!ack) begin
      check("ack_rise_timeout", 32'(ack), 32'd1);
      req = 1'b0;
      return;
    end
    model_push(d);
    hi = 1;
    for (int i = 0; i < extra; i++) begin
      tick();
      if (ack) hi++;
    end
    req = 1'b0;
    waited = 0;
    while (waited < 50) begin
      tick();
      waited++;
      if (ack) hi++;
      else break;
    end
    exp_hi = (extra + 1 > ACK_HOLD) ? extra + 1 : ACK_HOLD;
    check("ack_high_cycles", 32'(hi), 32'(exp_hi));
    check_counters("send");
  endtask

  task automatic pop_one();
    if (mq.size() == 0) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check_counters("pop_on_empty");
    end else begin
      check("rd_data", 32'(rd_data), 32'(mq[0]));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      void'(mq.pop_front());
      check_counters("pop");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // T1 reset
    do_reset();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_counters("rst");

    // T2 single byte
    send_byte(8'hA5, 0);
    check("t2_rd_data", 32'(rd_data), 32'hA5);
    check("t2_xor_sum", 32'(xor_sum), 32'hA5);
    pop_one();

    // T3 back-pressure
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h04, 0);
    send_byte(8'h08, 0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_xor", 32'(xor_sum), 32'h0F);
    req = 1'b1; data = 8'h10;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) seen = 1;
    end
    check("t3_ack_stalled", 32'(seen), 32'd0);
    check("t3_busy_stalled", 32'(busy), 32'd0);
    check("t3_pop_head", 32'(rd_data), 32'h01);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(mq.pop_front());
    check("t3_ack_after_pop", 32'(ack), 32'd0);
    tick();
    check("t3_ack_accept", 32'(ack), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    model_push(8'h10);
    req = 1'b0;
    seen = 0;
    while (ack && seen < 50) begin
      tick();
      seen++;
    end
    check_counters("t3_after");
    check("t3_order0", 32'(rd_data), 32'h02);
    while (mq.size() > 0) pop_one();

    // T4 slow master
    do_reset();
    send_byte(8'h5A, 5);
    check("t4_one_write", 32'(byte_cnt), 32'd1);

    // T5 concurrent push and pop
    do_reset();
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    req = 1'b1; data = 8'h33; rd_en = 1'b1;
    check("t5_head", 32'(rd_data), 32'h11);
    tick();
    rd_en = 1'b0;
    void'(mq.pop_front());
    model_push(8'h33);
    check("t5_ack", 32'(ack), 32'd1);
    req = 1'b0;
    seen = 0;
    while (ack && seen < 50) begin
      tick();
      seen++;
    end
    check_counters("t5_after");
    pop_one();
    pop_one();
    pop_one();

    // T6 reset mid-handshake, then counter wrap
    do_reset();
    send_byte(8'h77, 0);
    req = 1'b1; data = 8'h99;
    seen = 0;
    while (!ack && seen < 50) begin
      tick();
      seen++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    check("t6_ack", 32'(ack), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_byte_cnt", 32'(byte_cnt), 32'd0);
    mq.delete(); m_cnt = 0; m_xor = '0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'($urandom), int'($urandom_range(0, 2)));
      pop_one();
    end
    check("t6_wrap_cnt", 32'(byte_cnt), 32'd0);
    check("t6_wrap_xor", 32'(xor_sum), 32'(m_xor));

    // Random mix of handshakes and pops
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0 && mq.size() < DEPTH)
        send_byte(8'($urandom), int'($urandom_range(0, 4)));
      else
        pop_one();
    end
    while (mq.size() > 0) pop_one();
    pop_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
